// File: rtl/arb_requester.sv
// Requester agent for one port of a fixed-priority arbiter: issues a request,
// streams one beat per granted cycle, then holds off for a minimum idle gap.
module arb_requester #(
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned GAP     = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             grant,
    output logic             req,
    output logic             ready,
    output logic             busy,
    output logic             beat,
    output logic             done,
    output logic             err
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_GAP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               req_q, req_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               beat_q, beat_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    // Next-state, counters and pulse generation
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        to_cnt_d   = to_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && (len != '0)) begin
                    beat_cnt_d = len;
                    to_cnt_d   = '0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                // A grant in the timeout cycle still wins
                if (grant) begin
                    state_d = S_XFER;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_d == TO_W'(TIMEOUT)) begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                        err_d     = 1'b1;
                    end
                end
            end
            S_XFER: begin
                if (beat_cnt_q != '0) begin
                    beat_cnt_d = beat_cnt_q - LEN_W'(1);
                end
                if (!grant) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                    err_d     = 1'b1;
                end else if (beat_cnt_q == LEN_W'(1)) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                    done_d    = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q != GAP_W'(GAP)) begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
                // Leave once this cycle completes the gap and the grant has gone
                if ((gap_cnt_q >= GAP_W'(GAP - 1)) && !grant) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_d   = (state_d == S_REQ) || (state_d == S_XFER);
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        beat_d  = (state_d == S_XFER);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            req_q      <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            beat_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            req_q      <= req_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            beat_q     <= beat_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign req   = req_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign beat  = beat_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: timeline model of each job plus a three-port
// fixed-priority arbiter scenario.
module tb_arb_requester;

    localparam int TO = 15;
    localparam int GP = 2;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [3:0] len;
    logic       grant;
    logic       req, ready, busy, beat, done, err;

    logic       start3;
    logic [3:0] len3;
    logic [2:0] r3, g3, beat3, done3, err3, ready3, busy3;

    int errors = 0;
    int checks = 0;

    // Job timeline (cycle 0 = start cycle)
    int j_len, j_g0, j_g1, j_gc, j_xs, j_e, j_s, j_idle;
    bit j_ok;

    arb_requester #(.LEN_W(4), .TIMEOUT(TO), .GAP(GP)) dut (
        .clk(clk), .resetn(resetn), .start(start), .len(len), .grant(grant),
        .req(req), .ready(ready), .busy(busy), .beat(beat), .done(done), .err(err)
    );

    for (genvar i = 0; i < 3; i++) begin : g_port
        arb_requester #(.LEN_W(4), .TIMEOUT(TO), .GAP(GP)) u_req (
            .clk(clk), .resetn(resetn), .start(start3), .len(len3), .grant(g3[i]),
            .req(r3[i]), .ready(ready3[i]), .busy(busy3[i]), .beat(beat3[i]),
            .done(done3[i]), .err(err3[i])
        );
    end

    // Non-preemptive fixed-priority arbiter, grant registered one cycle after request
    always @(posedge clk) begin
        if (!resetn) g3 <= 3'b000;
        else if ((g3 & r3) != 3'b000) g3 <= g3;
        else if (r3[0]) g3 <= 3'b001;
        else if (r3[1]) g3 <= 3'b010;
        else if (r3[2]) g3 <= 3'b100;
        else g3 <= 3'b000;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit gr(input int c);
        return (c >= j_g0) && (c <= j_g1);
    endfunction

    task automatic plan_job(input int l, input int g0, input int g1);
        int c;
        j_len = l; j_g0 = g0; j_g1 = g1;
        j_gc = -1;
        for (int k = 1; k <= TO; k++) begin
            if (gr(k)) begin j_gc = k; break; end
        end
        if (j_gc < 0) begin
            j_xs = 0; j_e = TO; j_ok = 1'b0;
        end else begin
            j_xs = j_gc + 1;
            c = j_xs;
            forever begin
                if (!gr(c)) begin j_e = c; j_ok = 1'b0; break; end
                if (c - j_gc == l) begin j_e = c; j_ok = 1'b1; break; end
                c++;
            end
        end
        j_s = j_e + 1;
        c = j_s + GP - 1;
        while (gr(c)) c++;
        j_idle = c + 1;
    endtask

    // {ready, busy, req, beat, done, err}
    function automatic logic [5:0] exp_vec(input int c);
        bit rq, xf, gp, rd;
        int req_end;
        req_end = (j_gc < 0) ? TO : j_gc;
        rq = (c >= 1) && (c <= req_end);
        xf = (j_gc >= 0) && (c >= j_xs) && (c <= j_e);
        gp = (c >= j_s) && (c < j_idle);
        rd = !(rq || xf || gp);
        return {rd, !rd, rq || xf, xf, (c == j_s) && j_ok, (c == j_s) && !j_ok};
    endfunction

    function automatic logic [5:0] obs();
        return {ready, busy, req, beat, done, err};
    endfunction

    task automatic run_job(input string name, input int l, input int g0, input int g1,
                           input int extra);
        plan_job(l, g0, g1);
        for (int c = 0; c <= j_idle + 1; c++) begin
            checks++;
            if (obs() !== exp_vec(c)) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b (rdy,bsy,req,beat,done,err)",
                         name, c, obs(), exp_vec(c));
            end
            if (c == 0) begin
                start = 1'b1;
                len   = 4'(l);
            end else begin
                start = (c < j_idle) && ((extra == 2) ||
                        ((extra == 1) && ($urandom_range(0, 3) == 0)));
                len   = 4'($urandom_range(0, 15));
            end
            grant = gr(c);
            @(posedge clk); #1;
        end
        start = 1'b0;
        grant = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; grant = 1'b0; len = '0;
        start3 = 1'b0; len3 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 6'b100000) begin
            errors++;
            $display("FAIL reset_state: got %b expected 100000", obs());
        end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        run_job("nominal_len3", 3, 2, 6, 0);
        run_job("nominal_len1", 1, 2, 4, 0);
        run_job("nominal_len15", 15, 2, 18, 0);
    endtask

    task automatic test_timeout();
        run_job("timeout", 3, 1000, 999, 0);
    endtask

    task automatic test_timeout_boundary();
        run_job("grant_at_timeout", 3, TO, TO + 4, 0);
        run_job("grant_after_timeout", 2, TO + 1, TO + 3, 0);
    endtask

    task automatic test_grant_lost();
        run_job("grant_lost_len4", 4, 2, 3, 0);
        run_job("grant_lost_last", 3, 2, 4, 0);
    endtask

    task automatic test_extra_start();
        run_job("start_while_busy", 2, 2, 5, 2);
    endtask

    task automatic test_len_zero();
        start = 1'b1; len = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (obs() !== 6'b100000) begin
                errors++;
                $display("FAIL len_zero cycle %0d: got %b expected 100000", c, obs());
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_job();
        plan_job(4, 2, 7);
        for (int c = 0; c <= 4; c++) begin
            checks++;
            if (obs() !== exp_vec(c)) begin
                errors++;
                $display("FAIL reset_mid_job cycle %0d: got %b expected %b",
                         c, obs(), exp_vec(c));
            end
            start  = (c == 0);
            len    = 4'd4;
            grant  = gr(c);
            resetn = (c != 4);
            @(posedge clk); #1;
        end
        resetn = 1'b1;
        for (int c = 5; c <= 7; c++) begin
            checks++;
            if (obs() !== 6'b100000) begin
                errors++;
                $display("FAIL reset_mid_job_after cycle %0d: got %b expected 100000",
                         c, obs());
            end
            grant = (c == 5);
            @(posedge clk); #1;
        end
        grant = 1'b0;
    endtask

    task automatic test_random();
        int l, g0, g1, ex;
        for (int n = 0; n < 40; n++) begin
            l  = $urandom_range(1, 15);
            g0 = $urandom_range(1, TO + 3);
            g1 = g0 + $urandom_range(0, l + 2) - 1;
            ex = $urandom_range(0, 1);
            run_job($sformatf("random_%0d", n), l, g0, g1, ex);
        end
    endtask

    task automatic test_three_ports();
        int first [3];
        int nbeat [3];
        int ndone [3];
        int nerr  [3];
        int overlap;
        overlap = 0;
        for (int i = 0; i < 3; i++) begin
            first[i] = -1; nbeat[i] = 0; ndone[i] = 0; nerr[i] = 0;
        end
        for (int c = 0; c < 30; c++) begin
            if ($countones(beat3) > 1) overlap++;
            for (int i = 0; i < 3; i++) begin
                if (beat3[i]) begin
                    nbeat[i]++;
                    if (first[i] < 0) first[i] = c;
                end
                if (done3[i]) ndone[i]++;
                if (err3[i]) nerr[i]++;
            end
            start3 = (c == 0);
            len3   = 4'd3;
            @(posedge clk); #1;
        end
        start3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (first[i] !== 3 + 5 * i) begin
                errors++;
                $display("FAIL three_first_beat r%0d: got %0d expected %0d",
                         i + 1, first[i], 3 + 5 * i);
            end
            checks++;
            if ((nbeat[i] !== 3) || (ndone[i] !== 1) || (nerr[i] !== 0)) begin
                errors++;
                $display("FAIL three_counts r%0d: beats %0d done %0d err %0d expected 3/1/0",
                         i + 1, nbeat[i], ndone[i], nerr[i]);
            end
        end
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL three_overlap: got %0d overlapping cycles expected 0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_timeout_boundary();
        test_grant_lost();
        test_extra_start();
        test_len_zero();
        test_reset_mid_job();
        test_random();
        test_three_ports();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
